// File: rtl/mini_alu_pkg.sv
// Shared opcode and FSM state definitions for the mini_alu_v2 core.
package mini_alu_pkg;

  localparam int INSTR_WIDTH = 28;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LED  = 4'd1,
    OP_BLE  = 4'd2,
    OP_STO  = 4'd3,
    OP_ADD  = 4'd4,
    OP_JMP  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SMUL = 4'd7,
    OP_CALL = 4'd8,
    OP_RET  = 4'd9,
    OP_LCD  = 4'd10,
    OP_SLH  = 4'd11,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_EXEC     = 3'd1,
    ST_LCD_WAIT = 3'd2,
    ST_HALT     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  // Opcodes whose EXEC cycle commits a register-file write.
  function automatic logic writesRegister(input opcode_t op);
    case (op)
      OP_STO, OP_ADD, OP_SUB, OP_SMUL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mini_alu_v2_if.sv
// Return-address stack bus between the core FSM (master) and ret_stack (slave).
interface mini_alu_v2_if #(
  parameter int WIDTH   = 16,
  parameter int DEPTH_W = 4
);
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   pushData;
  logic [WIDTH-1:0]   topData;
  logic               full;
  logic               empty;
  logic [DEPTH_W-1:0] depth;

  modport master (output push, pop, pushData, input topData, full, empty, depth);
  modport slave  (input push, pop, pushData, output topData, full, empty, depth);
endinterface

// File: rtl/mini_alu_v2_ret_stack.sv
// LIFO of return addresses; topData is the most recently pushed entry (0 when empty).
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input logic          clock,
  input logic          reset,
  mini_alu_v2_if.slave stk
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depthR;
  logic [WIDTH-1:0] topS;

  // Select the entry just below the occupancy pointer.
  always_comb begin
    topS = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      topS = (DW'(i + 1) == depthR) ? mem[i] : topS;
    end
  end

  assign stk.topData = topS;
  assign stk.full    = (depthR == DW'(DEPTH));
  assign stk.empty   = (depthR == {DW{1'b0}});
  assign stk.depth   = depthR;

  // Occupancy counter; overflowing pushes and underflowing pops are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      depthR <= {DW{1'b0}};
    end else if (stk.push && !stk.full) begin
      depthR <= depthR + 1'b1;
    end else if (stk.pop && !stk.empty) begin
      depthR <= depthR - 1'b1;
    end else begin
      depthR <= depthR;
    end
  end

  // Entry storage, written at the current occupancy slot on push.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset && stk.push && !stk.full && (DW'(i) == depthR)) begin
        mem[i] <= stk.pushData;
      end
    end
  end

endmodule

// File: rtl/mini_alu_v2.sv
// Two-cycle FETCH/EXEC micro-core with a 256-entry register file, return stack,
// LED register and a nibble-wide LCD valid/ready sink.
module mini_alu_v2
  import mini_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IP_WIDTH    = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [INSTR_WIDTH-1:0]           iInstruction,
  input  logic                             iLCD_Ready,
  output logic [IP_WIDTH-1:0]              oIP,
  output logic [7:0]                       oLed,
  output logic [3:0]                       oLCD_Nibble,
  output logic                             oLCD_Valid,
  output logic                             oHalted,
  output logic                             oFault,
  output logic [$clog2(STACK_DEPTH+1)-1:0] oStackDepth
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  state_t                 stateR;
  logic [INSTR_WIDTH-1:0] instrR;
  logic [IP_WIDTH-1:0]    ipR;
  logic [7:0]             ledR;
  logic [3:0]             nibbleR;
  logic                   validR;
  logic                   haltedR;
  logic                   faultR;
  logic [DATA_WIDTH-1:0]  regFile [256];

  opcode_t               op;
  logic [7:0]            dst;
  logic [7:0]            src1;
  logic [7:0]            src0;
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;
  logic [IP_WIDTH-1:0]   ipNextS;
  logic [IP_WIDTH-1:0]   ipDstS;
  logic                  execS;
  logic                  bleTakenS;
  logic                  regWeS;
  logic [DATA_WIDTH-1:0] regWdS;

  mini_alu_v2_if #(.WIDTH(IP_WIDTH), .DEPTH_W(DEPTH_W)) stk ();

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (IP_WIDTH)
  ) uRetStack (
    .clock (Clock),
    .reset (Reset),
    .stk   (stk)
  );

  assign op        = opcode_t'(instrR[27:24]);
  assign dst       = instrR[23:16];
  assign src1      = instrR[15:8];
  assign src0      = instrR[7:0];
  assign opA       = regFile[src1];
  assign opB       = regFile[src0];
  assign ipNextS   = ipR + IP_WIDTH'(1);
  assign ipDstS    = IP_WIDTH'(dst);
  assign execS     = (stateR == ST_EXEC);
  assign bleTakenS = ($signed(opA) <= $signed(opB));

  assign stk.push     = execS && (op == OP_CALL) && !stk.full;
  assign stk.pop      = execS && (op == OP_RET) && !stk.empty;
  assign stk.pushData = ipNextS;

  // Write-back value; the low DATA_WIDTH bits of a product are sign-agnostic.
  always_comb begin
    regWdS = {DATA_WIDTH{1'b0}};
    case (op)
      OP_STO:  regWdS = DATA_WIDTH'({src1, src0});
      OP_ADD:  regWdS = opA + opB;
      OP_SUB:  regWdS = opA - opB;
      OP_SMUL: regWdS = opA * opB;
      default: regWdS = {DATA_WIDTH{1'b0}};
    endcase
    regWeS = execS && writesRegister(op) && !Reset;
  end

  // Register file write port; contents survive Reset.
  always_ff @(posedge Clock) begin
    if (regWeS) begin
      regFile[dst] <= regWdS;
    end
  end

  // Core sequencer with registered IP, LED, LCD and status outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateR  <= ST_FETCH;
      instrR  <= {INSTR_WIDTH{1'b0}};
      ipR     <= {IP_WIDTH{1'b0}};
      ledR    <= 8'd0;
      nibbleR <= 4'd0;
      validR  <= 1'b0;
      haltedR <= 1'b0;
      faultR  <= 1'b0;
    end else begin
      case (stateR)
        ST_FETCH: begin
          instrR <= iInstruction;
          stateR <= ST_EXEC;
        end
        ST_EXEC: begin
          stateR <= ST_FETCH;
          case (op)
            OP_LED: begin
              ledR <= opA[7:0];
              ipR  <= ipNextS;
            end
            OP_BLE:  ipR <= bleTakenS ? ipDstS : ipNextS;
            OP_JMP:  ipR <= ipDstS;
            OP_CALL: begin
              if (stk.full) begin
                faultR <= 1'b1;
                stateR <= ST_FAULT;
              end else begin
                ipR <= ipDstS;
              end
            end
            OP_RET: begin
              if (stk.empty) begin
                faultR <= 1'b1;
                stateR <= ST_FAULT;
              end else begin
                ipR <= stk.topData;
              end
            end
            OP_LCD: begin
              nibbleR <= opA[7:4];
              validR  <= 1'b1;
              stateR  <= ST_LCD_WAIT;
            end
            OP_SLH: begin
              nibbleR <= opA[3:0];
              validR  <= 1'b1;
              stateR  <= ST_LCD_WAIT;
            end
            OP_HALT: begin
              haltedR <= 1'b1;
              stateR  <= ST_HALT;
            end
            default: ipR <= ipNextS;
          endcase
        end
        ST_LCD_WAIT: begin
          if (iLCD_Ready) begin
            validR <= 1'b0;
            ipR    <= ipNextS;
            stateR <= ST_FETCH;
          end
        end
        ST_HALT:  stateR <= ST_HALT;
        ST_FAULT: stateR <= ST_FAULT;
        default: begin
          faultR <= 1'b1;
          stateR <= ST_FAULT;
        end
      endcase
    end
  end

  assign oIP         = ipR;
  assign oLed        = ledR;
  assign oLCD_Nibble = nibbleR;
  assign oLCD_Valid  = validR;
  assign oHalted     = haltedR;
  assign oFault      = faultR;
  assign oStackDepth = stk.depth;

endmodule

// File: tb/tb_mini_alu_v2.sv
// Directed bench for mini_alu_v2: an instruction-level model checked every cycle,
// plus hand-computed checkpoints and a direct ret_stack check through the interface.
module tb_mini_alu_v2;
  localparam int SD = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iLCD_Ready = 1'b0;
  logic [27:0] iInstruction;
  logic [15:0] oIP;
  logic [7:0]  oLed;
  logic [3:0]  oLCD_Nibble;
  logic        oLCD_Valid, oHalted, oFault;
  logic [1:0]  oStackDepth;

  logic [27:0] rom [256];
  int nChecks = 0;
  int nErrs   = 0;
  bit checkEn = 1'b0;

  always #5 Clock = ~Clock;
  assign iInstruction = rom[oIP[7:0]];

  mini_alu_v2 #(.DATA_WIDTH(16), .IP_WIDTH(16), .STACK_DEPTH(SD)) dut (
    .Clock(Clock), .Reset(Reset), .iInstruction(iInstruction), .iLCD_Ready(iLCD_Ready),
    .oIP(oIP), .oLed(oLed), .oLCD_Nibble(oLCD_Nibble), .oLCD_Valid(oLCD_Valid),
    .oHalted(oHalted), .oFault(oFault), .oStackDepth(oStackDepth)
  );

  logic stReset = 1'b1;
  mini_alu_v2_if #(.WIDTH(8), .DEPTH_W(2)) sBus ();
  ret_stack #(.DEPTH(3), .WIDTH(8)) uStack (.clock(Clock), .reset(stReset), .stk(sBus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference model
  logic [15:0] mReg [256];
  logic [15:0] mStack [$];
  logic [15:0] mIP = 16'd0;
  logic [7:0]  mLed = 8'd0;
  logic [3:0]  mNib = 4'd0;
  bit mValid = 1'b0, mHalted = 1'b0, mFault = 1'b0, mPhase = 1'b0, mWaiting = 1'b0;

  initial for (int i = 0; i < 256; i++) mReg[i] = 16'd0;

  task automatic modelExec();
    logic [27:0] ins;
    logic [3:0]  opc;
    logic [7:0]  d, s1, s0;
    int          prod;
    ins = rom[mIP[7:0]];
    opc = ins[27:24]; d = ins[23:16]; s1 = ins[15:8]; s0 = ins[7:0];
    case (opc)
      4'd1: begin mLed = mReg[s1][7:0]; mIP = mIP + 16'd1; end
      4'd2: mIP = ($signed(mReg[s1]) <= $signed(mReg[s0])) ? {8'd0, d} : mIP + 16'd1;
      4'd3: begin mReg[d] = {s1, s0}; mIP = mIP + 16'd1; end
      4'd4: begin mReg[d] = mReg[s1] + mReg[s0]; mIP = mIP + 16'd1; end
      4'd5: mIP = {8'd0, d};
      4'd6: begin mReg[d] = mReg[s1] - mReg[s0]; mIP = mIP + 16'd1; end
      4'd7: begin
        prod = $signed(mReg[s1]) * $signed(mReg[s0]);
        mReg[d] = 16'(prod); mIP = mIP + 16'd1;
      end
      4'd8: begin
        if (mStack.size() == SD) mFault = 1'b1;
        else begin mStack.push_back(mIP + 16'd1); mIP = {8'd0, d}; end
      end
      4'd9: begin
        if (mStack.size() == 0) mFault = 1'b1;
        else mIP = mStack.pop_back();
      end
      4'd10: begin mNib = mReg[s1][7:4]; mValid = 1'b1; mWaiting = 1'b1; end
      4'd11: begin mNib = mReg[s1][3:0]; mValid = 1'b1; mWaiting = 1'b1; end
      4'd15: mHalted = 1'b1;
      default: mIP = mIP + 16'd1;
    endcase
  endtask

  // Compare DUT to model, then advance the model across the coming rising edge.
  always @(negedge Clock) begin
    if (checkEn) begin
      check("ip", 32'(oIP), 32'(mIP));
      check("led", 32'(oLed), 32'(mLed));
      check("lcd_valid", 32'(oLCD_Valid), 32'(mValid));
      check("lcd_nibble", 32'(oLCD_Nibble), 32'(mNib));
      check("halted", 32'(oHalted), 32'(mHalted));
      check("fault", 32'(oFault), 32'(mFault));
      check("stack_depth", 32'(oStackDepth), 32'(mStack.size()));
    end
    if (Reset) begin
      mIP = 16'd0; mLed = 8'd0; mNib = 4'd0; mValid = 1'b0; mHalted = 1'b0;
      mFault = 1'b0; mPhase = 1'b0; mWaiting = 1'b0; mStack.delete();
    end else if (mHalted || mFault) begin
      mPhase = 1'b0;
    end else if (mWaiting) begin
      if (iLCD_Ready) begin
        mWaiting = 1'b0; mValid = 1'b0; mIP = mIP + 16'd1; mPhase = 1'b0;
      end
    end else if (!mPhase) begin
      mPhase = 1'b1;
    end else begin
      modelExec();
      mPhase = 1'b0;
    end
  end

  task automatic put(input int addr, input logic [3:0] op, input logic [7:0] d,
                     input logic [7:0] s1, input logic [7:0] s0);
    rom[addr] = {op, d, s1, s0};
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 28'd0;
  endtask

  // Called right after a rising edge; leaves Reset low just after the next one.
  task automatic restart();
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic stackOp(input bit push, input bit pop, input logic [7:0] data);
    sBus.push = push; sBus.pop = pop; sBus.pushData = data;
    @(posedge Clock); #1;
    sBus.push = 1'b0; sBus.pop = 1'b0;
  endtask

  initial begin
    clearRom();
    sBus.push = 1'b0; sBus.pop = 1'b0; sBus.pushData = 8'd0;

    // Direct return-stack check through the interface
    @(posedge Clock); #1;
    stReset = 1'b0;
    check("st_empty0", 32'(sBus.empty), 32'd1);
    stackOp(1'b1, 1'b0, 8'h11);
    stackOp(1'b1, 1'b0, 8'h22);
    stackOp(1'b1, 1'b0, 8'h33);
    check("st_full", 32'(sBus.full), 32'd1);
    check("st_top3", 32'(sBus.topData), 32'h33);
    stackOp(1'b1, 1'b0, 8'h44);
    check("st_depth_ovf", 32'(sBus.depth), 32'd3);
    check("st_top_ovf", 32'(sBus.topData), 32'h33);
    stackOp(1'b0, 1'b1, 8'h00);
    check("st_pop1", 32'(sBus.topData), 32'h22);
    stackOp(1'b0, 1'b1, 8'h00);
    stackOp(1'b0, 1'b1, 8'h00);
    stackOp(1'b0, 1'b1, 8'h00);
    check("st_depth_udf", 32'(sBus.depth), 32'd0);
    check("st_empty", 32'(sBus.empty), 32'd1);

    // Program 1: arithmetic, LED, SMUL wrap, BLE, JMP, HALT
    put(0, 4'd3, 8'd1, 8'h00, 8'h05);
    put(1, 4'd3, 8'd2, 8'hFF, 8'hFD);
    put(2, 4'd4, 8'd3, 8'd1, 8'd2);
    put(3, 4'd1, 8'd0, 8'd3, 8'd0);
    put(4, 4'd3, 8'd4, 8'h01, 8'h00);
    put(5, 4'd7, 8'd5, 8'd4, 8'd4);
    put(6, 4'd1, 8'd0, 8'd5, 8'd0);
    put(7, 4'd6, 8'd6, 8'd1, 8'd2);
    put(8, 4'd1, 8'd0, 8'd6, 8'd0);
    put(9, 4'd3, 8'd7, 8'hFF, 8'hFF);
    put(10, 4'd3, 8'd8, 8'h00, 8'h01);
    put(11, 4'd2, 8'd20, 8'd7, 8'd8);
    put(12, 4'd15, 8'd0, 8'd0, 8'd0);
    put(20, 4'd4, 8'd1, 8'd1, 8'd1);
    put(21, 4'd1, 8'd0, 8'd1, 8'd0);
    put(22, 4'd2, 8'd30, 8'd8, 8'd7);
    put(23, 4'd5, 8'd40, 8'd0, 8'd0);
    put(40, 4'd15, 8'd0, 8'd0, 8'd0);
    Reset = 1'b0;
    checkEn = 1'b1;
    check("rst_ip", 32'(oIP), 32'd0);
    check("rst_led", 32'(oLed), 32'd0);
    check("rst_valid", 32'(oLCD_Valid), 32'd0);
    check("rst_depth", 32'(oStackDepth), 32'd0);
    cycles(8);  check("p1_led_add", 32'(oLed), 32'h02); check("p1_ip4", 32'(oIP), 32'd4);
    cycles(6);  check("p1_led_smul", 32'(oLed), 32'h00); check("p1_ip7", 32'(oIP), 32'd7);
    cycles(4);  check("p1_led_sub", 32'(oLed), 32'h08);
    cycles(6);  check("p1_ble_taken", 32'(oIP), 32'd20);
    cycles(6);  check("p1_ble_not", 32'(oIP), 32'd23); check("p1_led_dup", 32'(oLed), 32'h0A);
    cycles(2);  check("p1_jmp", 32'(oIP), 32'd40);
    cycles(2);  check("p1_halted", 32'(oHalted), 32'd1);
    cycles(10); check("p1_halt_sticky", 32'(oHalted), 32'd1); check("p1_halt_ip", 32'(oIP), 32'd40);

    // Program 2: nested calls to depth 2, then overflow
    clearRom();
    put(0, 4'd8, 8'd10, 8'd0, 8'd0);
    put(1, 4'd8, 8'd30, 8'd0, 8'd0);
    put(10, 4'd8, 8'd20, 8'd0, 8'd0);
    put(11, 4'd9, 8'd0, 8'd0, 8'd0);
    put(20, 4'd3, 8'd9, 8'h00, 8'h33);
    put(21, 4'd1, 8'd0, 8'd9, 8'd0);
    put(22, 4'd9, 8'd0, 8'd0, 8'd0);
    put(30, 4'd8, 8'd40, 8'd0, 8'd0);
    put(40, 4'd8, 8'd50, 8'd0, 8'd0);
    restart();
    cycles(4);  check("p2_call2_ip", 32'(oIP), 32'd20); check("p2_depth2", 32'(oStackDepth), 32'd2);
    cycles(6);  check("p2_ret1_ip", 32'(oIP), 32'd11); check("p2_led", 32'(oLed), 32'h33);
    cycles(2);  check("p2_ret2_ip", 32'(oIP), 32'd1); check("p2_depth0", 32'(oStackDepth), 32'd0);
    cycles(6);  check("p2_ovf_fault", 32'(oFault), 32'd1); check("p2_ovf_ip", 32'(oIP), 32'd40);
    cycles(6);  check("p2_fault_sticky", 32'(oFault), 32'd1); check("p2_ip_frozen", 32'(oIP), 32'd40);

    // Program 3: RET on empty stack, then Reset clears the fault
    clearRom();
    put(0, 4'd9, 8'd0, 8'd0, 8'd0);
    restart();
    cycles(2);  check("p3_udf_fault", 32'(oFault), 32'd1); check("p3_udf_ip", 32'(oIP), 32'd0);
    Reset = 1'b1;
    cycles(1);  check("p3_rst_fault", 32'(oFault), 32'd0); check("p3_rst_ip", 32'(oIP), 32'd0);

    // Program 4: LCD handshake with back-pressure, then SLH
    clearRom();
    put(0, 4'd3, 8'd10, 8'h00, 8'hA5);
    put(1, 4'd10, 8'd0, 8'd10, 8'd0);
    put(2, 4'd11, 8'd0, 8'd10, 8'd0);
    put(3, 4'd15, 8'd0, 8'd0, 8'd0);
    iLCD_Ready = 1'b0;
    restart();
    cycles(4);  check("p4_valid", 32'(oLCD_Valid), 32'd1); check("p4_nib_hi", 32'(oLCD_Nibble), 32'hA);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check("p4_hold_valid", 32'(oLCD_Valid), 32'd1);
      check("p4_hold_nib", 32'(oLCD_Nibble), 32'hA);
      check("p4_hold_ip", 32'(oIP), 32'd1);
    end
    iLCD_Ready = 1'b1;
    cycles(1);  check("p4_done_valid", 32'(oLCD_Valid), 32'd0); check("p4_done_ip", 32'(oIP), 32'd2);
    iLCD_Ready = 1'b0;
    cycles(2);  check("p4_slh_valid", 32'(oLCD_Valid), 32'd1); check("p4_nib_lo", 32'(oLCD_Nibble), 32'h5);
    iLCD_Ready = 1'b1;
    cycles(1);  check("p4_slh_ip", 32'(oIP), 32'd3);
    cycles(2);  check("p4_halted", 32'(oHalted), 32'd1);
    iLCD_Ready = 1'b0;

    // Program 5: Reset during LCD_WAIT, then run to HALT with the sink always ready
    restart();
    cycles(4);  check("p5_valid", 32'(oLCD_Valid), 32'd1);
    Reset = 1'b1;
    cycles(1);  check("p5_rst_valid", 32'(oLCD_Valid), 32'd0); check("p5_rst_ip", 32'(oIP), 32'd0);
    check("p5_rst_nib", 32'(oLCD_Nibble), 32'd0);
    Reset = 1'b0;
    iLCD_Ready = 1'b1;
    cycles(20); check("p5_halted", 32'(oHalted), 32'd1); check("p5_ip", 32'(oIP), 32'd3);
    check("p5_nib", 32'(oLCD_Nibble), 32'h5);
    cycles(10); check("p5_halt_sticky", 32'(oHalted), 32'd1);

    @(negedge Clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nErrs);
    $finish;
  end

endmodule

// File: doc/mini_alu_v2.md
MINI_ALU_V2 -- requirements
Module: mini_alu_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: register-file word width, at least 8.
REQ-002 SHALL have parameter IP_WIDTH, default 16: instruction-pointer width, at least 8.
REQ-003 SHALL have parameter STACK_DEPTH, default 8: return-address stack entries, at least 1.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port iInstruction, input, 28 bits: opcode[27:24], dst[23:16], src1[15:8], src0[7:0].
REQ-007 SHALL have port iLCD_Ready, input, 1 bit: the LCD sink accepts the nibble this cycle.
REQ-008 SHALL have port oIP, output, IP_WIDTH bits: instruction ROM address.
REQ-009 SHALL have port oLed, output, 8 bits: registered LED value.
REQ-010 SHALL have port oLCD_Nibble, output, 4 bits: nibble offered to the LCD sink.
REQ-011 SHALL have port oLCD_Valid, output, 1 bit: the nibble on oLCD_Nibble is valid.
REQ-012 SHALL have port oHalted, output, 1 bit: core is in HALT.
REQ-013 SHALL have port oFault, output, 1 bit: core is in FAULT after a stack overflow or underflow.
REQ-014 SHALL have port oStackDepth, output, clog2(STACK_DEPTH+1) bits: current stack occupancy.

Function
REQ-015 SHALL use opcodes NOP=0, LED=1, BLE=2, STO=3, ADD=4, JMP=5, SUB=6, SMUL=7, CALL=8, RET=9, LCD=10, SLH=11, HALT=15; codes 12-14 execute as NOP.
REQ-016 SHALL contain a 256 x DATA_WIDTH register file: combinational read, one write port written at the end of EXEC.
REQ-017 SHALL implement the FSM FETCH -> EXEC -> FETCH; EXEC -> LCD_WAIT for LCD/SLH; EXEC -> HALT for HALT; EXEC -> FAULT on a stack error.
REQ-018 SHALL, in FETCH, drive oIP = IP and latch iInstruction at the clock edge; the ROM is combinational.
REQ-019 SHALL make every non-LCD instruction take exactly 2 cycles.
REQ-020 SHALL compute ADD, SUB and SMUL arithmetic: R[dst] = R[src1] op R[src0], two's complement, truncated to DATA_WIDTH bits; SUB is src1 - src0.
REQ-021 SHALL make STO write R[dst] = {src1,src0}, zero-extended or truncated to DATA_WIDTH.
REQ-022 SHALL make JMP set IP = dst zero-extended; all other non-branching instructions set IP = IP+1, wrapping modulo 2^IP_WIDTH.
REQ-023 SHALL make BLE set IP = dst if signed R[src1] <= R[src0], else IP+1.
REQ-024 SHALL make LED load oLed with R[src1][7:0] in EXEC.
REQ-025 SHALL make CALL push IP+1 and set IP = dst; if the stack is full, SHALL push nothing and enter FAULT.
REQ-026 SHALL make RET pop into IP; if the stack is empty, SHALL enter FAULT with IP unchanged.
REQ-027 SHALL, for LCD, offer R[src1][7:4], and for SLH offer R[src1][3:0], with oLCD_Valid=1 in LCD_WAIT.
REQ-028 SHALL complete the transfer on the first cycle with oLCD_Valid & iLCD_Ready: IP = IP+1, next state FETCH; SHALL hold oLCD_Nibble stable while waiting.
REQ-029 SHALL keep HALT and FAULT sticky until Reset; oIP holds its value and no register, LED or stack writes occur.
REQ-030 SHALL allow a write to dst when dst equals src0 or src1; operands are read before the write takes effect.

Reset
REQ-031 SHALL, on Reset, load IP=0, state FETCH, oLed=0, oLCD_Valid=0, oLCD_Nibble=0, oHalted=0, oFault=0, stack depth 0.
REQ-032 SHALL leave register-file contents unchanged on Reset.
REQ-033 SHALL let Reset override any state, including LCD_WAIT mid-handshake; oLCD_Valid drops in the next cycle.

Structure
REQ-034 SHALL place opcode constants and FSM state encodings in the shared package mini_alu_pkg.
REQ-035 SHALL implement the return stack as sub-module ret_stack (parameter DEPTH; push, pop, full, empty, depth outputs).

Verification
REQ-036 SHALL cover: STO R1=5, STO R2=-3, ADD R3=R1+R2, LED R3 -> oLed=0x02, 2 cycles per instruction.
REQ-037 SHALL cover: SMUL 0x0100*0x0100 at DATA_WIDTH=16 -> R[dst]=0x0000; BLE with -1 <= 1 -> branch taken.
REQ-038 SHALL cover: nested CALLs to STACK_DEPTH=2 -> RETs return correctly; a third CALL -> oFault=1, IP frozen.
REQ-039 SHALL cover: RET with empty stack -> oFault=1; Reset -> oFault=0, IP=0.
REQ-040 SHALL cover: LCD with R[src1]=0xA5 and iLCD_Ready low 5 cycles -> nibble 0xA held valid; SLH -> 0x5.
REQ-041 SHALL cover: Reset asserted during LCD_WAIT -> oLCD_Valid=0 next cycle, IP=0; HALT -> oHalted=1 and sticky.
